// File: rtl/obi_xbar_pkg.sv
// Shared types and helpers for the OBI crossbar.
// Address decode result and round-robin pointer arithmetic.
package obi_xbar_pkg;

   localparam int IDX_W = 8;

   typedef struct packed {
      logic             hit;
      logic [IDX_W-1:0] idx;
      logic             err;
   } dec_t;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rr_next(input int m, input int n);
      return (m + 1 >= n) ? 0 : m + 1;
   endfunction

endpackage

// File: rtl/obi_rr_arb.sv
// Round-robin arbiter with a registered priority pointer.
// Pointer moves past the winner only when advance is high.
module obi_rr_arb
   import obi_xbar_pkg::*;
#(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] gnt
);

   localparam int PW = clog2_min1(N);

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_next;
   logic          found;
   int            i;

   always_comb begin
      gnt      = '0;
      ptr_next = ptr;
      found    = 1'b0;
      i        = 0;
      for (int k = 0; k < N; k++) begin
         i = int'(ptr) + k;
         if (i >= N) i = i - N;
         if (!found && req[i]) begin
            found    = 1'b1;
            gnt[i]   = 1'b1;
            ptr_next = PW'(rr_next(i, N));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= ptr_next;
      end
   end

endmodule

// File: rtl/obi_xbar.sv
// OBI crossbar: N masters to M slaves with per-slave round-robin,
// in-order ID FIFOs and a decode-error responder.
module obi_xbar
   import obi_xbar_pkg::*;
#(
   parameter int MASTERS         = 3,
   parameter int SLAVES          = 4,
   parameter int SLV_OUTSTANDING = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [MASTERS-1:0]       master_req_i,
   input  logic [MASTERS-1:0]       master_we_i,
   input  logic [MASTERS-1:0][3:0]  master_be_i,
   input  logic [MASTERS-1:0][31:0] master_addr_i,
   input  logic [MASTERS-1:0][31:0] master_wdata_i,
   output logic [MASTERS-1:0]       master_gnt_o,
   output logic [MASTERS-1:0]       master_rvalid_o,
   output logic [MASTERS-1:0]       master_err_o,
   output logic [MASTERS-1:0][31:0] master_rdata_o,
   input  logic [SLAVES-1:0][31:0]  slave_addr_mask_i,
   input  logic [SLAVES-1:0][31:0]  slave_addr_base_i,
   output logic [SLAVES-1:0]        slave_req_o,
   output logic [SLAVES-1:0]        slave_we_o,
   output logic [SLAVES-1:0][3:0]   slave_be_o,
   output logic [SLAVES-1:0][31:0]  slave_addr_o,
   output logic [SLAVES-1:0][31:0]  slave_wdata_o,
   input  logic [SLAVES-1:0]        slave_gnt_i,
   input  logic [SLAVES-1:0]        slave_rvalid_i,
   input  logic [SLAVES-1:0][31:0]  slave_rdata_i,
   output logic                     proto_err_o
);

   localparam int MID_W = clog2_min1(MASTERS);
   localparam int PW    = clog2_min1(SLV_OUTSTANDING);
   localparam int CW    = $clog2(SLV_OUTSTANDING + 1);

   logic [MASTERS-1:0] busy;
   logic [MASTERS-1:0] err_pend;
   logic [MASTERS-1:0] rsp;
   logic [MASTERS-1:0] elig;
   logic [MASTERS-1:0] derr;
   dec_t               dec [MASTERS];

   logic [MID_W-1:0]   mem [SLAVES][SLV_OUTSTANDING];
   logic [PW-1:0]      wr [SLAVES];
   logic [PW-1:0]      rd [SLAVES];
   logic [CW-1:0]      cnt [SLAVES];
   logic [MID_W-1:0]   head [SLAVES];
   logic [MID_W-1:0]   push_id [SLAVES];
   logic [SLAVES-1:0]  pop;
   logic [SLAVES-1:0]  push;
   logic [SLAVES-1:0]  full;
   logic [SLAVES-1:0]  stray;

   logic [MASTERS-1:0] arb_req [SLAVES];
   logic [MASTERS-1:0] arb_gnt [SLAVES];

   // Response routing, decode and eligibility; independent of arbitration.
   always_comb begin
      master_rvalid_o = '0;
      master_err_o    = '0;
      master_rdata_o  = '0;
      pop             = '0;
      full            = '0;
      stray           = '0;
      for (int s = 0; s < SLAVES; s++) begin
         head[s]  = mem[s][rd[s]];
         pop[s]   = slave_rvalid_i[s] && (cnt[s] != '0);
         stray[s] = slave_rvalid_i[s] && (cnt[s] == '0);
         full[s]  = (cnt[s] == CW'(SLV_OUTSTANDING));
         if (pop[s]) begin
            master_rvalid_o[head[s]] = 1'b1;
            master_rdata_o[head[s]]  = slave_rdata_i[s];
         end
      end
      for (int m = 0; m < MASTERS; m++) begin
         if (err_pend[m]) begin
            master_rvalid_o[m] = 1'b1;
            master_err_o[m]    = 1'b1;
            master_rdata_o[m]  = '0;
         end
      end
      rsp = master_rvalid_o;
      for (int m = 0; m < MASTERS; m++) begin
         dec[m]     = '0;
         dec[m].err = 1'b1;
         for (int s = 0; s < SLAVES; s++) begin
            if (!dec[m].hit &&
                ((master_addr_i[m] & slave_addr_mask_i[s])
                 == slave_addr_base_i[s])) begin
               dec[m].hit = 1'b1;
               dec[m].idx = IDX_W'(s);
               dec[m].err = 1'b0;
            end
         end
         elig[m] = rst_ni && master_req_i[m] && (!busy[m] || rsp[m]);
         derr[m] = elig[m] && dec[m].err;
      end
      for (int s = 0; s < SLAVES; s++) begin
         arb_req[s] = '0;
         for (int m = 0; m < MASTERS; m++) begin
            arb_req[s][m] = elig[m] && dec[m].hit
                            && (dec[m].idx == IDX_W'(s));
         end
      end
   end

   for (genvar s = 0; s < SLAVES; s++) begin : g_arb
      obi_rr_arb #(.N(MASTERS)) u_arb (
         .clk     (clk_i),
         .rst_n   (rst_ni),
         .req     (arb_req[s]),
         .advance (push[s]),
         .gnt     (arb_gnt[s])
      );
   end

   // Slave-side muxing and grants; a full FIFO may still accept on a pop.
   always_comb begin
      slave_req_o   = '0;
      slave_we_o    = '0;
      slave_be_o    = '0;
      slave_addr_o  = '0;
      slave_wdata_o = '0;
      master_gnt_o  = '0;
      push          = '0;
      for (int s = 0; s < SLAVES; s++) begin
         push_id[s]     = '0;
         slave_req_o[s] = (|arb_req[s]) && (!full[s] || pop[s]);
         for (int m = 0; m < MASTERS; m++) begin
            if (arb_gnt[s][m] && slave_req_o[s]) begin
               push_id[s]       = MID_W'(m);
               slave_we_o[s]    = master_we_i[m];
               slave_be_o[s]    = master_be_i[m];
               slave_addr_o[s]  = master_addr_i[m];
               slave_wdata_o[s] = master_wdata_i[m];
            end
         end
         push[s] = slave_req_o[s] && slave_gnt_i[s];
         for (int m = 0; m < MASTERS; m++) begin
            if (arb_gnt[s][m] && push[s]) master_gnt_o[m] = 1'b1;
         end
      end
      master_gnt_o = master_gnt_o | derr;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy        <= '0;
         err_pend    <= '0;
         proto_err_o <= 1'b0;
         for (int s = 0; s < SLAVES; s++) begin
            wr[s]  <= '0;
            rd[s]  <= '0;
            cnt[s] <= '0;
         end
      end else begin
         busy        <= (busy & ~rsp) | master_gnt_o;
         err_pend    <= derr;
         proto_err_o <= proto_err_o | (|stray);
         for (int s = 0; s < SLAVES; s++) begin
            if (push[s]) begin
               wr[s] <= (wr[s] == PW'(SLV_OUTSTANDING - 1)) ? '0 : wr[s] + 1'b1;
            end
            if (pop[s]) begin
               rd[s] <= (rd[s] == PW'(SLV_OUTSTANDING - 1)) ? '0 : rd[s] + 1'b1;
            end
            cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int s = 0; s < SLAVES; s++) begin
         if (push[s]) mem[s][wr[s]] <= push_id[s];
      end
   end

endmodule

// File: tb/tb_obi_xbar.sv
// Directed bench for obi_xbar: routing, round-robin,
// decode errors, outstanding limit, protocol error, reset.
module tb_obi_xbar;

   logic             clk_i;
   logic             rst_ni;
   logic [2:0]       master_req_i;
   logic [2:0]       master_we_i;
   logic [2:0][3:0]  master_be_i;
   logic [2:0][31:0] master_addr_i;
   logic [2:0][31:0] master_wdata_i;
   logic [2:0]       master_gnt_o;
   logic [2:0]       master_rvalid_o;
   logic [2:0]       master_err_o;
   logic [2:0][31:0] master_rdata_o;
   logic [3:0][31:0] slave_addr_mask_i;
   logic [3:0][31:0] slave_addr_base_i;
   logic [3:0]       slave_req_o;
   logic [3:0]       slave_we_o;
   logic [3:0][3:0]  slave_be_o;
   logic [3:0][31:0] slave_addr_o;
   logic [3:0][31:0] slave_wdata_o;
   logic [3:0]       slave_gnt_i;
   logic [3:0]       slave_rvalid_i;
   logic [3:0][31:0] slave_rdata_i;
   logic             proto_err_o;

   int compared;
   int mismatched;

   obi_xbar dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .master_req_i      (master_req_i),
      .master_we_i       (master_we_i),
      .master_be_i       (master_be_i),
      .master_addr_i     (master_addr_i),
      .master_wdata_i    (master_wdata_i),
      .master_gnt_o      (master_gnt_o),
      .master_rvalid_o   (master_rvalid_o),
      .master_err_o      (master_err_o),
      .master_rdata_o    (master_rdata_o),
      .slave_addr_mask_i (slave_addr_mask_i),
      .slave_addr_base_i (slave_addr_base_i),
      .slave_req_o       (slave_req_o),
      .slave_we_o        (slave_we_o),
      .slave_be_o        (slave_be_o),
      .slave_addr_o      (slave_addr_o),
      .slave_wdata_o     (slave_wdata_o),
      .slave_gnt_i       (slave_gnt_i),
      .slave_rvalid_i    (slave_rvalid_i),
      .slave_rdata_i     (slave_rdata_i),
      .proto_err_o       (proto_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      #3;
      compared++;
      if (master_gnt_o !== 3'b000 || slave_req_o !== 4'b0000) begin
         $display("FAIL reset_gnt_req: got gnt=%b req=%b want 0", master_gnt_o, slave_req_o);
         mismatched++;
      end
      compared++;
      if (master_rvalid_o !== 3'b000 || proto_err_o !== 1'b0) begin
         $display("FAIL reset_rvalid: got rvalid=%b perr=%b want 0", master_rvalid_o, proto_err_o);
         mismatched++;
      end
      tick();
      rst_ni = 1'b1;
      #1;
      compared++;
      if (master_err_o !== 3'b000 || master_rdata_o !== '0 || slave_addr_o !== '0) begin
         $display("FAIL reset_data: got err=%b rdata=%h saddr=%h want 0", master_err_o, master_rdata_o, slave_addr_o);
         mismatched++;
      end
   endtask

   task automatic test_single_read();
      tick();
      master_req_i[0]  = 1'b1;
      master_addr_i[0] = 32'h2000_0004;
      master_we_i[0]   = 1'b0;
      master_be_i[0]   = 4'hF;
      slave_gnt_i[1]   = 1'b1;
      #1;
      compared++;
      if (slave_req_o !== 4'b0010) begin
         $display("FAIL single_sreq: got %b want 0010", slave_req_o);
         mismatched++;
      end
      compared++;
      if (slave_addr_o[1] !== 32'h2000_0004 || slave_be_o[1] !== 4'hF) begin
         $display("FAIL single_saddr: got %h/%h want 20000004/f", slave_addr_o[1], slave_be_o[1]);
         mismatched++;
      end
      compared++;
      if (master_gnt_o !== 3'b001) begin
         $display("FAIL single_gnt: got %b want 001", master_gnt_o);
         mismatched++;
      end
      tick();
      master_req_i[0] = 1'b0;
      slave_gnt_i[1]  = 1'b0;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b000 || slave_req_o !== 4'b0000) begin
         $display("FAIL single_idle: got rvalid=%b sreq=%b want 0", master_rvalid_o, slave_req_o);
         mismatched++;
      end
      tick();
      slave_rvalid_i[1] = 1'b1;
      slave_rdata_i[1]  = 32'hDEAD_BEEF;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b001 || master_err_o !== 3'b000) begin
         $display("FAIL single_rvalid: got rvalid=%b err=%b want 001/000", master_rvalid_o, master_err_o);
         mismatched++;
      end
      compared++;
      if (master_rdata_o[0] !== 32'hDEAD_BEEF) begin
         $display("FAIL single_rdata: got %h want deadbeef", master_rdata_o[0]);
         mismatched++;
      end
      tick();
      slave_rvalid_i[1] = 1'b0;
   endtask

   task automatic test_round_robin();
      logic [2:0] exp;
      tick();
      for (int m = 0; m < 3; m++) begin
         master_req_i[m]  = 1'b1;
         master_addr_i[m] = 32'h1000_0000 + 32'(m * 4);
      end
      slave_gnt_i[0] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         slave_rvalid_i[0] = (c > 0);
         slave_rdata_i[0]  = 32'h100 + 32'(c);
         #1;
         exp = 3'b001 << (c % 3);
         compared++;
         if (master_gnt_o !== exp) begin
            $display("FAIL rr_gnt%0d: got %b want %b", c, master_gnt_o, exp);
            mismatched++;
         end
         if (c > 0) begin
            exp = 3'b001 << ((c - 1) % 3);
            compared++;
            if (master_rvalid_o !== exp || master_rdata_o[(c-1)%3] !== 32'h100 + 32'(c)) begin
               $display("FAIL rr_rsp%0d: got %b/%h want %b/%h", c, master_rvalid_o,
                        master_rdata_o[(c-1)%3], exp, 32'h100 + 32'(c));
               mismatched++;
            end
         end
         tick();
      end
      master_req_i      = '0;
      slave_gnt_i[0]    = 1'b0;
      slave_rvalid_i[0] = 1'b1;
      slave_rdata_i[0]  = 32'h106;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b100 || master_rdata_o[2] !== 32'h106) begin
         $display("FAIL rr_drain: got %b/%h want 100/106", master_rvalid_o, master_rdata_o[2]);
         mismatched++;
      end
      tick();
      slave_rvalid_i[0] = 1'b0;
   endtask

   task automatic test_decode_err();
      tick();
      master_req_i[1]  = 1'b1;
      master_addr_i[1] = 32'h9000_0000;
      #1;
      compared++;
      if (master_gnt_o !== 3'b010 || slave_req_o !== 4'b0000) begin
         $display("FAIL derr_gnt: got gnt=%b sreq=%b want 010/0000", master_gnt_o, slave_req_o);
         mismatched++;
      end
      compared++;
      if (master_rvalid_o !== 3'b000) begin
         $display("FAIL derr_early: got rvalid=%b want 000", master_rvalid_o);
         mismatched++;
      end
      tick();
      master_req_i[1] = 1'b0;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b010 || master_err_o !== 3'b010 || master_rdata_o[1] !== 32'h0) begin
         $display("FAIL derr_rsp: got %b/%b/%h want 010/010/0", master_rvalid_o, master_err_o, master_rdata_o[1]);
         mismatched++;
      end
      tick();
      compared++;
      if (master_rvalid_o !== 3'b000 || master_err_o !== 3'b000) begin
         $display("FAIL derr_once: got %b/%b want 000/000", master_rvalid_o, master_err_o);
         mismatched++;
      end
   endtask

   task automatic test_outstanding();
      tick();
      for (int m = 0; m < 3; m++) begin
         master_req_i[m]  = 1'b1;
         master_addr_i[m] = 32'h3000_0000 + 32'(m * 4);
      end
      slave_gnt_i[2] = 1'b1;
      #1;
      compared++;
      if (master_gnt_o !== 3'b001 || slave_req_o !== 4'b0100) begin
         $display("FAIL out_g0: got %b/%b want 001/0100", master_gnt_o, slave_req_o);
         mismatched++;
      end
      tick();
      compared++;
      if (master_gnt_o !== 3'b010) begin
         $display("FAIL out_g1: got %b want 010", master_gnt_o);
         mismatched++;
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         compared++;
         if (slave_req_o !== 4'b0000 || master_gnt_o !== 3'b000) begin
            $display("FAIL out_full%0d: got %b/%b want 0000/000", c, slave_req_o, master_gnt_o);
            mismatched++;
         end
      end
      tick();
      slave_rvalid_i[2] = 1'b1;
      slave_rdata_i[2]  = 32'hA;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b001 || master_rdata_o[0] !== 32'hA) begin
         $display("FAIL out_r0: got %b/%h want 001/a", master_rvalid_o, master_rdata_o[0]);
         mismatched++;
      end
      compared++;
      if (slave_req_o !== 4'b0100 || master_gnt_o !== 3'b100) begin
         $display("FAIL out_pushpop: got %b/%b want 0100/100", slave_req_o, master_gnt_o);
         mismatched++;
      end
      tick();
      master_req_i     = '0;
      slave_gnt_i[2]   = 1'b0;
      slave_rdata_i[2] = 32'hB;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b010 || master_rdata_o[1] !== 32'hB) begin
         $display("FAIL out_r1: got %b/%h want 010/b", master_rvalid_o, master_rdata_o[1]);
         mismatched++;
      end
      tick();
      slave_rdata_i[2] = 32'hC;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b100 || master_rdata_o[2] !== 32'hC) begin
         $display("FAIL out_r2: got %b/%h want 100/c", master_rvalid_o, master_rdata_o[2]);
         mismatched++;
      end
      tick();
      slave_rvalid_i[2] = 1'b0;
   endtask

   task automatic test_proto_err();
      tick();
      slave_rvalid_i[3] = 1'b1;
      slave_rdata_i[3]  = 32'h55;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b000 || proto_err_o !== 1'b0) begin
         $display("FAIL perr_drop: got rvalid=%b perr=%b want 000/0", master_rvalid_o, proto_err_o);
         mismatched++;
      end
      tick();
      slave_rvalid_i[3] = 1'b0;
      compared++;
      if (proto_err_o !== 1'b1) begin
         $display("FAIL perr_set: got %b want 1", proto_err_o);
         mismatched++;
      end
      tick();
      tick();
      compared++;
      if (proto_err_o !== 1'b1) begin
         $display("FAIL perr_sticky: got %b want 1", proto_err_o);
         mismatched++;
      end
   endtask

   task automatic test_reset_mid();
      tick();
      master_req_i[0]  = 1'b1;
      master_addr_i[0] = 32'h2000_0000;
      master_req_i[1]  = 1'b1;
      master_addr_i[1] = 32'h3000_0000;
      slave_gnt_i[1]   = 1'b1;
      slave_gnt_i[2]   = 1'b1;
      #1;
      compared++;
      if (master_gnt_o !== 3'b011) begin
         $display("FAIL rmid_gnt: got %b want 011", master_gnt_o);
         mismatched++;
      end
      tick();
      master_req_i[1]   = 1'b0;
      master_addr_i[0]  = 32'h1000_0000;
      slave_gnt_i       = 4'b0001;
      slave_rvalid_i[1] = 1'b1;
      rst_ni            = 1'b0;
      #1;
      compared++;
      if (master_gnt_o !== 3'b000 || slave_req_o !== 4'b0000) begin
         $display("FAIL rmid_out: got gnt=%b sreq=%b want 0", master_gnt_o, slave_req_o);
         mismatched++;
      end
      compared++;
      if (master_rvalid_o !== 3'b000 || proto_err_o !== 1'b0) begin
         $display("FAIL rmid_rsp: got rvalid=%b perr=%b want 0", master_rvalid_o, proto_err_o);
         mismatched++;
      end
      tick();
      slave_rvalid_i[1] = 1'b0;
      tick();
      rst_ni           = 1'b1;
      master_addr_i[0] = 32'h2000_0000;
      slave_gnt_i      = 4'b0010;
      #1;
      compared++;
      if (master_gnt_o !== 3'b001 || slave_req_o !== 4'b0010) begin
         $display("FAIL rmid_fresh: got %b/%b want 001/0010", master_gnt_o, slave_req_o);
         mismatched++;
      end
      tick();
      master_req_i      = '0;
      slave_gnt_i       = '0;
      slave_rvalid_i[2] = 1'b1;
      #1;
      compared++;
      if (master_rvalid_o !== 3'b000) begin
         $display("FAIL rmid_stale: got %b want 000", master_rvalid_o);
         mismatched++;
      end
      tick();
      slave_rvalid_i[2] = 1'b0;
      slave_rvalid_i[1] = 1'b1;
      slave_rdata_i[1]  = 32'h77;
      #1;
      compared++;
      if (proto_err_o !== 1'b1 || master_rvalid_o !== 3'b001 || master_rdata_o[0] !== 32'h77) begin
         $display("FAIL rmid_after: got perr=%b rvalid=%b rdata=%h want 1/001/77",
                  proto_err_o, master_rvalid_o, master_rdata_o[0]);
         mismatched++;
      end
      tick();
      slave_rvalid_i[1] = 1'b0;
   endtask

   initial begin
      compared       = 0;
      mismatched     = 0;
      rst_ni         = 1'b0;
      master_req_i   = '0;
      master_we_i    = '0;
      master_be_i    = '0;
      master_addr_i  = '0;
      master_wdata_i = '0;
      slave_gnt_i    = '0;
      slave_rvalid_i = '0;
      slave_rdata_i  = '0;
      for (int s = 0; s < 4; s++) begin
         slave_addr_mask_i[s] = 32'hF000_0000;
         slave_addr_base_i[s] = 32'(s + 1) << 28;
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_decode_err();
      test_outstanding();
      test_proto_err();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
